// File: rtl/alu_cdb.sv
// alu_cdb -- RV32I integer ALU with a 2-entry in-order result FIFO that
// broadcasts onto the common data bus (CDB).
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   rdy                 global enable, low freezes all state
//   ex_*                instruction offer from the reservation station
//   ex_ready            block can accept an instruction this cycle
//   flush               ROB misprediction clear (empties the FIFO)
//   cdb_grant           arbiter grants the head entry
//   update_RS_*         head entry broadcast (valid/tag/value/jump/target)
//
// Optional feature: define ALU_BYPASS_EN to let a result computed while the
// FIFO is empty and the grant is already present go straight to the CDB
// in the same cycle, without being stored.
//
// Opcode map (op_map encoding):
//   bit5=0 ALU ops, even = immediate form (except SUB), odd = register form
//     ADDI=0  ADD=1  SUB=2  SLTI=4 SLT=5 SLTIU=6 SLTU=7 XORI=8 XOR=9
//     ORI=10 OR=11 ANDI=12 AND=13 SLLI=14 SLL=15 SRLI=16 SRL=17
//     SRAI=18 SRA=19 LUI=20 AUIPC=22 JAL=24
//   bit5=1 control flow
//     BEQ=32 BNE=33 BLT=34 BGE=35 BLTU=36 BGEU=37 JALR=38
//   Any other code yields val=0, jump=0, target=0.
module alu_cdb (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ex_instr_valid,
  input  logic [5:0]  ex_opcode_id,
  input  logic [31:0] ex_vj,
  input  logic [31:0] ex_vk,
  input  logic [31:0] ex_A,
  input  logic [31:0] ex_pc,
  input  logic [3:0]  ex_ROB_pos,
  output logic        ex_ready,
  input  logic        flush,
  input  logic        cdb_grant,
  output logic        update_RS_valid,
  output logic [3:0]  update_RS_ROB_pos,
  output logic [31:0] update_RS_val,
  output logic        update_RS_jump,
  output logic [31:0] update_RS_target
);

  localparam logic [5:0] OP_ADDI  = 6'd0,  OP_ADD  = 6'd1,  OP_SUB   = 6'd2;
  localparam logic [5:0] OP_SLTI  = 6'd4,  OP_SLT  = 6'd5,  OP_SLTIU = 6'd6;
  localparam logic [5:0] OP_SLTU  = 6'd7,  OP_XORI = 6'd8,  OP_XOR   = 6'd9;
  localparam logic [5:0] OP_ORI   = 6'd10, OP_OR   = 6'd11, OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_AND   = 6'd13, OP_SLLI = 6'd14, OP_SLL   = 6'd15;
  localparam logic [5:0] OP_SRLI  = 6'd16, OP_SRL  = 6'd17, OP_SRAI  = 6'd18;
  localparam logic [5:0] OP_SRA   = 6'd19, OP_LUI  = 6'd20, OP_AUIPC = 6'd22;
  localparam logic [5:0] OP_JAL   = 6'd24, OP_BEQ  = 6'd32, OP_BNE   = 6'd33;
  localparam logic [5:0] OP_BLT   = 6'd34, OP_BGE  = 6'd35, OP_BLTU  = 6'd36;
  localparam logic [5:0] OP_BGEU  = 6'd37, OP_JALR = 6'd38;

  typedef struct packed {
    logic [3:0]  pos;
    logic [31:0] val;
    logic        jump;
    logic [31:0] target;
  } entry_t;

  entry_t      fifo [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;

  entry_t      res;
  logic [31:0] op2;
  logic [4:0]  shamt;
  logic        accept, push, pop;

  // Immediate-form ALU ops are the even bit5=0 codes; SUB is the one even
  // register-form op. JALR takes its offset from A as well.
  always_comb begin
    if (ex_opcode_id == OP_JALR ||
        (!ex_opcode_id[5] && !ex_opcode_id[0] && ex_opcode_id != OP_SUB))
      op2 = ex_A;
    else
      op2 = ex_vk;
  end

  assign shamt = op2[4:0];

  always_comb begin
    res        = '0;
    res.pos    = ex_ROB_pos;
    unique case (ex_opcode_id)
      OP_ADDI, OP_ADD:   res.val = ex_vj + op2;
      OP_SUB:            res.val = ex_vj - op2;
      OP_SLTI, OP_SLT:   res.val = {31'b0, $signed(ex_vj) < $signed(op2)};
      OP_SLTIU, OP_SLTU: res.val = {31'b0, ex_vj < op2};
      OP_XORI, OP_XOR:   res.val = ex_vj ^ op2;
      OP_ORI, OP_OR:     res.val = ex_vj | op2;
      OP_ANDI, OP_AND:   res.val = ex_vj & op2;
      OP_SLLI, OP_SLL:   res.val = ex_vj << shamt;
      OP_SRLI, OP_SRL:   res.val = ex_vj >> shamt;
      OP_SRAI, OP_SRA:   res.val = $unsigned($signed(ex_vj) >>> shamt);
      OP_LUI:            res.val = ex_A;
      OP_AUIPC:          res.val = ex_pc + ex_A;
      OP_JAL: begin
        res.val    = ex_pc + 32'd4;
        res.jump   = 1'b1;
        res.target = ex_pc + ex_A;
      end
      OP_JALR: begin
        res.val    = ex_pc + 32'd4;
        res.jump   = 1'b1;
        res.target = (ex_vj + op2) & ~32'd1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        res.target = ex_pc + ex_A;
        unique case (ex_opcode_id)
          OP_BEQ:  res.jump = (ex_vj == op2);
          OP_BNE:  res.jump = (ex_vj != op2);
          OP_BLT:  res.jump = ($signed(ex_vj) <  $signed(op2));
          OP_BGE:  res.jump = ($signed(ex_vj) >= $signed(op2));
          OP_BLTU: res.jump = (ex_vj <  op2);
          default: res.jump = (ex_vj >= op2);
        endcase
      end
      default: ;
    endcase
  end

  // ex_ready depends only on registered count and rdy, never on cdb_grant.
  assign ex_ready = (count < 2'd2) && rdy;
  assign accept   = rdy && !flush && ex_instr_valid && ex_ready;
  assign pop      = rdy && (count != 2'd0) && cdb_grant;

`ifdef ALU_BYPASS_EN
  logic bypass;
  // Empty FIFO and grant already present: broadcast now, store nothing.
  assign bypass = accept && (count == 2'd0) && cdb_grant;
  assign push   = accept && !bypass;

  always_comb begin
    update_RS_valid   = (count != 2'd0) || bypass;
    update_RS_ROB_pos = bypass ? res.pos    : fifo[rd_ptr].pos;
    update_RS_val     = bypass ? res.val    : fifo[rd_ptr].val;
    update_RS_jump    = bypass ? res.jump   : fifo[rd_ptr].jump;
    update_RS_target  = bypass ? res.target : fifo[rd_ptr].target;
  end
`else
  assign push = accept;

  always_comb begin
    update_RS_valid   = (count != 2'd0);
    update_RS_ROB_pos = fifo[rd_ptr].pos;
    update_RS_val     = fifo[rd_ptr].val;
    update_RS_jump    = fifo[rd_ptr].jump;
    update_RS_target  = fifo[rd_ptr].target;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
    end else if (rdy) begin
      if (flush) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          fifo[wr_ptr] <= res;
          wr_ptr       <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        // push+pop at count=1 leaves count at 1 with the new entry at head
        if (push && !pop)      count <= count + 2'd1;
        else if (pop && !push) count <= count - 2'd1;
      end
    end
  end

endmodule

// File: doc/alu_cdb.md
ALU_CDB -- requirements
Module: alu_cdb

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 The port list SHALL be as follows, clock and reset first:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- rdy  in  1  global enable; low freezes the block
- ex_instr_valid  in  1  RS offers an instruction
- ex_opcode_id  in  6  op_map.v opcode
- ex_vj  in  32  operand 1
- ex_vk  in  32  operand 2
- ex_A  in  32  immediate
- ex_pc  in  32  instruction PC
- ex_ROB_pos  in  4  destination ROB tag
- ex_ready  out  1  block can accept this cycle
- flush  in  1  ROB misprediction clear
- cdb_grant  in  1  CDB arbiter grants head entry
- update_RS_valid  out  1  result on CDB
- update_RS_ROB_pos  out  4  result tag
- update_RS_val  out  32  result value
- update_RS_jump  out  1  branch/jump taken
- update_RS_target  out  32  redirect target

Function
REQ-003 The block SHALL accept an instruction on a clk edge when rst=1, rdy=1, flush=0, ex_instr_valid=1 and ex_ready=1.
REQ-004 The second operand SHALL be ex_A when opcode is JALR or (opcode[5]=0, opcode[0]=0, opcode!=SUB); otherwise it SHALL be ex_vk.
REQ-005 ALU results SHALL follow RV32I semantics, modulo 2^32; shift amounts SHALL be operand2[4:0]; SLT/SRA/BLT/BGE SHALL be signed; SLTU/BLTU/BGEU SHALL be unsigned.
REQ-006 For branches: val=0, jump=condition, target=ex_pc+ex_A.
- JAL: val=ex_pc+4, jump=1, target=ex_pc+ex_A.
- JALR: val=ex_pc+4, jump=1, target=(ex_vj+ex_A)&~1.
- LUI: val=ex_A. AUIPC: val=ex_pc+ex_A.
- Every non-jump op: jump=0, target=0.
- An unknown opcode SHALL broadcast val=0, jump=0.
REQ-007 Accepted results SHALL enter a 2-entry in-order FIFO of {ROB_pos, val, jump, target}.
- Without the REQ-016 macro, minimum accept-to-broadcast latency SHALL be 1 cycle.
REQ-008 ex_ready SHALL be (count<2) && rdy; it SHALL be computed from registered state only, independent of cdb_grant.
REQ-009 update_RS_valid SHALL be (count!=0); the update_RS_* data fields SHALL show the head entry.
REQ-010 The head SHALL be popped on a clk edge when update_RS_valid=1, cdb_grant=1 and rdy=1; cdb_grant SHALL be ignored while update_RS_valid=0.
REQ-011 Simultaneous push and pop at count=1 SHALL leave count=1 with the new entry at the head; wrap-around of the pointers SHALL preserve order.
REQ-012 flush=1 SHALL empty the FIFO at the next edge, drop any same-cycle accept and pop, and take priority over push and pop.
REQ-013 When rdy=0, all state SHALL hold and outputs SHALL remain stable.

Reset
REQ-014 When rst=0 at a clk edge, count, pointers and all FIFO storage SHALL clear to 0, so all update_RS_* outputs read 0.
REQ-015 Reset SHALL override flush, rdy and any in-flight accept, including reset asserted mid-operation with a full FIFO.

Configuration
REQ-016 The macro ALU_BYPASS_EN SHALL control same-cycle bypass:
- Defined: when count=0, an accepting cycle with cdb_grant=1 SHALL drive the computed result combinationally on update_RS_* with update_RS_valid=1; that result is consumed and not stored.
- Defined, cdb_grant=0: the result SHALL be stored as in REQ-007.
- Not defined: no combinational path from ex_* to update_RS_* SHALL exist.

Verification
REQ-017 ADD vj=5, vk=7, ROB_pos=3, grant=1: the next cycle SHALL show valid=1, pos=3, val=12, jump=0.
REQ-018 BLT vj=0xFFFFFFFF, vk=1, pc=0x100, A=0x20: the bench SHALL see jump=1, target=0x120, val=0. Then SRAI vj=0x80000000, A=0x24: the bench SHALL see val=0xF8000000.
REQ-019 With grant held 0 and three back-to-back offers: ex_ready SHALL drop after 2 accepts. After grant rises, the tags SHALL broadcast in issue order, one per cycle.
REQ-020 FIFO full plus a same-cycle accept with flush=1: the next cycle SHALL show valid=0, count=0, ex_ready=1.
REQ-021 rst=0 with 2 entries pending: the next cycle SHALL show all update_RS_* = 0. With ALU_BYPASS_EN, empty FIFO, grant=1, JALR vj=0x1003, A=4, pc=0x40: the same cycle SHALL show val=0x44, target=0x1006.
